// File: rtl/transmitting_igmp.sv
// IGMP message builder: captures header fields, sums the message into an Internet checksum,
// then streams 32-bit words over valid/ready. Define IGMP_V3_QUERY_EN for v3-format queries.
module transmitting_igmp #(
    parameter int GAP_CYCLES  = 2,
    parameter int STALL_LIMIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  typea,
    input  logic [7:0]  mrc,
    input  logic [31:0] groupadd,
    input  logic        s,
    input  logic [2:0]  qrv,
    input  logic [7:0]  qqic,
    input  logic [15:0] source,
    input  logic [31:0] sourceadd,
    output logic        ready_in,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, CALC, FOLD, SEND, GAP} state_t;

    localparam logic [15:0] GAP_LIM   = 16'(GAP_CYCLES);
    localparam logic [15:0] STALL_LIM = 16'(STALL_LIMIT);

    state_t      state;
    logic [7:0]  r_type;
    logic [7:0]  r_mrc;
    logic [31:0] r_grp;
    logic [2:0]  nwords;
    logic [1:0]  idx;
    logic [17:0] acc;
    logic [15:0] csum;
    logic [15:0] gap_cnt;
    logic [15:0] stall_cnt;

`ifdef IGMP_V3_QUERY_EN
    logic        r_s;
    logic [2:0]  r_qrv;
    logic [7:0]  r_qqic;
    logic [15:0] r_src;
    logic [31:0] r_sadd;
`else
    logic        unused_v3;
    assign unused_v3 = ^{s, qrv, qqic, sourceadd};
`endif

    logic        type_ok;
    logic        src_ok;
    logic [2:0]  n_req;
    logic [7:0]  mrc_eff;
    logic [2:0]  last_idx;
    logic [1:0]  nxt_idx;
    logic [3:0][31:0] msg_w;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        type_ok = (typea == 8'h11) || (typea == 8'h16) || (typea == 8'h17);
        mrc_eff = (typea == 8'h11) ? mrc : 8'h00;
`ifdef IGMP_V3_QUERY_EN
        src_ok  = (source <= 16'd1);
        n_req   = (typea == 8'h11) ? (source[0] ? 3'd4 : 3'd3) : 3'd2;
`else
        // v2 queries carry no source list, so the source count is irrelevant for them
        src_ok  = (typea == 8'h11) || (source <= 16'd1);
        n_req   = 3'd2;
`endif
    end

    // csum holds 0 while summing, so word 0 contributes a zero checksum field
    always_comb begin
        msg_w[0] = {r_type, r_mrc, csum};
        msg_w[1] = r_grp;
`ifdef IGMP_V3_QUERY_EN
        msg_w[2] = {4'b0000, r_s, r_qrv, r_qqic, r_src};
        msg_w[3] = r_sadd;
`else
        msg_w[2] = 32'h0;
        msg_w[3] = 32'h0;
`endif
    end

    assign last_idx = nwords - 3'd1;
    assign nxt_idx  = idx + 2'd1;
    assign fold1    = {1'b0, acc[15:0]} + {15'b0, acc[17:16]};
    assign fold2    = fold1[15:0] + {15'b0, fold1[16]};

    // Two halves plus the pending carry of a partial sum always fit in 18 bits
    function automatic logic [17:0] csum_add(input logic [17:0] a, input logic [31:0] w);
        return {2'b0, a[15:0]} + {16'b0, a[17:16]} + {2'b0, w[31:16]} + {2'b0, w[15:0]};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            r_type    <= 8'h0;
            r_mrc     <= 8'h0;
            r_grp     <= 32'h0;
            nwords    <= 3'd0;
            idx       <= 2'd0;
            acc       <= 18'h0;
            csum      <= 16'h0;
            gap_cnt   <= 16'h0;
            stall_cnt <= 16'h0;
            ready_in  <= 1'b1;
            tx_data   <= 32'h0;
            tx_valid  <= 1'b0;
            tx_last   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef IGMP_V3_QUERY_EN
            r_s       <= 1'b0;
            r_qrv     <= 3'd0;
            r_qqic    <= 8'h0;
            r_src     <= 16'h0;
            r_sadd    <= 32'h0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (type_ok && src_ok) begin
                            r_type   <= typea;
                            r_mrc    <= mrc_eff;
                            r_grp    <= groupadd;
                            nwords   <= n_req;
                            idx      <= 2'd0;
                            acc      <= 18'h0;
                            csum     <= 16'h0;
                            ready_in <= 1'b0;
                            state    <= CALC;
`ifdef IGMP_V3_QUERY_EN
                            r_s      <= s;
                            r_qrv    <= qrv;
                            r_qqic   <= qqic;
                            r_src    <= source;
                            r_sadd   <= sourceadd;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    acc <= csum_add(acc, msg_w[idx]);
                    if ({1'b0, idx} == last_idx) begin
                        idx   <= 2'd0;
                        state <= FOLD;
                    end else begin
                        idx <= nxt_idx;
                    end
                end
                FOLD: begin
                    csum      <= ~fold2;
                    stall_cnt <= 16'h0;
                    state     <= SEND;
                end
                SEND: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= msg_w[idx];
                        tx_last  <= ({1'b0, idx} == last_idx);
                    end else if (tx_ready) begin
                        stall_cnt <= 16'h0;
                        if (tx_last) begin
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            done     <= 1'b1;
                            gap_cnt  <= 16'h0;
                            state    <= GAP;
                        end else begin
                            idx     <= nxt_idx;
                            tx_data <= msg_w[nxt_idx];
                            tx_last <= ({1'b0, nxt_idx} == last_idx);
                        end
                    end else if (STALL_LIMIT > 0) begin
                        if (stall_cnt + 16'd1 == STALL_LIM) begin
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            err      <= 1'b1;
                            gap_cnt  <= 16'h0;
                            state    <= GAP;
                        end else begin
                            stall_cnt <= stall_cnt + 16'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LIM) begin
                        ready_in <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
